// File: rtl/regs_wr_arbiter_pkg.sv
// regs_wr_arbiter_pkg
//   Shared widths and FSM state encoding for the register-file write-port
//   arbiter. Imported by regs_wr_arbiter.
package regs_wr_arbiter_pkg;

  localparam int DEF_CPU_WIDTH      = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WPEND = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/regs_wr_arbiter.sv
// regs_wr_arbiter
//   Owns the single write port of the integer register file. Core writeback
//   always wins and passes straight through; JTAG debug accesses use a
//   4-phase req/ack handshake and are granted on core-idle cycles. JTAG reads
//   are sequenced here too, with forwarding of a same-cycle core write.
//   A JTAG write that waits too long raises hold_req_o so the core frees one
//   cycle for it.
//
// Ports
//   clk, rst_n                           clock, async active-low reset
//   core_wr_en/addr/data_i               writeback stage write request
//   hold_req_o                           ask core to skip writeback next cycle
//   jtag_req/we/addr/wdata_i             debug module access request
//   jtag_ack_o, jtag_rdata_o             access complete / read result
//   rf_wr_en/addr/data_o                 regs_file write port
//   rf_rd_addr_o, rf_rd_data_i           regs_file debug read port
//
// state | meaning
// IDLE  | waiting for jtag_req_i
// WPEND | JTAG write captured, waiting for a core-idle cycle
// READ  | one cycle: sample regs_file (or forwarded core data)
// RESP  | ack high, waiting for jtag_req_i to drop
module regs_wr_arbiter
  import regs_wr_arbiter_pkg::*;
#(
  parameter int CPU_WIDTH      = DEF_CPU_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int STARVE_MAX     = 8,
  parameter int CNT_W          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] core_wr_addr_i,
  input  logic [CPU_WIDTH-1:0]      core_wr_data_i,
  output logic                      hold_req_o,
  input  logic                      jtag_req_i,
  input  logic                      jtag_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] jtag_addr_i,
  input  logic [CPU_WIDTH-1:0]      jtag_wdata_i,
  output logic                      jtag_ack_o,
  output logic [CPU_WIDTH-1:0]      jtag_rdata_o,
  output logic                      rf_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [CPU_WIDTH-1:0]      rf_wr_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_o,
  input  logic [CPU_WIDTH-1:0]      rf_rd_data_i
);

  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  arb_state_e                state;
  logic [CNT_W-1:0]          wait_cnt;
  logic [CNT_W-1:0]          wait_cnt_inc;
  logic [REG_ADDR_WIDTH-1:0] cap_addr;
  logic [CPU_WIDTH-1:0]      cap_wdata;
  logic [CPU_WIDTH-1:0]      cap_rdata;
  logic                      ack_q;
  logic                      hold_q;
  logic                      fwd_hit;

  assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign fwd_hit      = core_wr_en_i && (core_wr_addr_i == cap_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_rdata <= '0;
      ack_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jtag_req_i) begin
            cap_addr  <= jtag_addr_i;
            cap_wdata <= jtag_wdata_i;
            wait_cnt  <= '0;
            hold_q    <= 1'b0;
            state     <= jtag_we_i ? ST_WPEND : ST_READ;
          end
        end
        ST_WPEND: begin
          if (core_wr_en_i) begin
            // Hold is registered from the post-increment count, so it shows
            // up in the cycle after the STARVE_MAX-th blocked cycle.
            wait_cnt <= wait_cnt_inc;
            hold_q   <= (wait_cnt_inc >= STARVE_CNT);
          end else begin
            // Write port is ours this cycle (see always_comb below).
            hold_q <= 1'b0;
            ack_q  <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_READ: begin
          if (cap_addr == '0)
            cap_rdata <= '0;
          else if (fwd_hit)
            cap_rdata <= core_wr_data_i;
          else
            cap_rdata <= rf_rd_data_i;
          ack_q <= 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!jtag_req_i) begin
            ack_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          ack_q  <= 1'b0;
          hold_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Core write has absolute priority; a pending JTAG write uses the port only
  // on a core-idle cycle. Writes to x0 are suppressed but still acked.
  always_comb begin
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = core_wr_addr_i;
    rf_wr_data_o = core_wr_data_i;
    if (!rst_n) begin
      rf_wr_en_o = 1'b0;
    end else if (core_wr_en_i) begin
      rf_wr_en_o = 1'b1;
    end else if (state == ST_WPEND) begin
      rf_wr_en_o   = (cap_addr != '0);
      rf_wr_addr_o = cap_addr;
      rf_wr_data_o = cap_wdata;
    end
  end

  assign rf_rd_addr_o = cap_addr;
  assign jtag_ack_o   = ack_q;
  assign jtag_rdata_o = cap_rdata;
  assign hold_req_o   = hold_q;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
module tb_regs_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_wr_en_i;
  logic [4:0]  core_wr_addr_i;
  logic [31:0] core_wr_data_i;
  logic        hold_req_o;
  logic        jtag_req_i;
  logic        jtag_we_i;
  logic [4:0]  jtag_addr_i;
  logic [31:0] jtag_wdata_i;
  logic        jtag_ack_o;
  logic [31:0] jtag_rdata_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_addr_o;
  logic [31:0] rf_wr_data_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regs_wr_arbiter #(
    .CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .STARVE_MAX(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wr_en_i(core_wr_en_i), .core_wr_addr_i(core_wr_addr_i),
    .core_wr_data_i(core_wr_data_i), .hold_req_o(hold_req_o),
    .jtag_req_i(jtag_req_i), .jtag_we_i(jtag_we_i), .jtag_addr_i(jtag_addr_i),
    .jtag_wdata_i(jtag_wdata_i), .jtag_ack_o(jtag_ack_o),
    .jtag_rdata_o(jtag_rdata_o), .rf_wr_en_o(rf_wr_en_o),
    .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_i(rf_rd_data_i)
  );

  // Simple register-file model; x0 deliberately holds junk so the arbiter's
  // zero forcing on reads is observable.
  logic [31:0] mem [32];
  always @(posedge clk) if (rf_wr_en_o) mem[rf_wr_addr_o] <= rf_wr_data_o;
  assign rf_rd_data_i = mem[rf_rd_addr_o];

  typedef struct {
    logic        ce;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        rq;
    logic        we;
    logic [4:0]  ja;
    logic [31:0] jd;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ack;
    logic        e_hold;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ce, logic [4:0] ca, logic [31:0] cd,
                              logic rq, logic we, logic [4:0] ja, logic [31:0] jd,
                              logic e_en, logic [4:0] e_addr, logic [31:0] e_data,
                              logic e_ack, logic e_hold, logic chk_rd, logic [31:0] e_rd);
    vec_t v;
    v.ce = ce; v.ca = ca; v.cd = cd; v.rq = rq; v.we = we; v.ja = ja; v.jd = jd;
    v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data; v.e_ack = e_ack;
    v.e_hold = e_hold; v.chk_rd = chk_rd; v.e_rd = e_rd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = a; jtag_wdata_i = '0;
    cyc(); cyc();
    @(negedge clk);
    chk({tag, "_ack"}, {31'd0, jtag_ack_o}, 32'd1);
    chk({tag, "_rdata"}, jtag_rdata_o, exp);
    cyc();
    jtag_req_i = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk({tag, "_ack_low"}, {31'd0, jtag_ack_o}, 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000 + i * 32'h11;
    mem[0] = 32'h0BAD_0000;
    rst_n = 1'b0;
    core_wr_en_i = 1'b0; core_wr_addr_i = '0; core_wr_data_i = '0;
    jtag_req_i = 1'b0; jtag_we_i = 1'b0; jtag_addr_i = '0; jtag_wdata_i = '0;

    // ---------------- table ----------------
    // JTAG write x5 = DEADBEEF, idle core: write cycle 1, ack cycle 2
    add(0,0,0, 1,1,5,32'hDEADBEEF, 0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,1,5,32'hDEADBEEF, 1,5,32'hDEADBEEF,        0,0, 0,0);
    add(0,0,0, 1,1,5,32'hDEADBEEF, 0,0,0,                   1,0, 0,0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 0,0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);
    // JTAG read x5
    add(0,0,0, 1,0,5,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,5,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,5,0,            0,0,0,                   1,0, 1,32'hDEADBEEF);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 1,32'hDEADBEEF);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);
    // core passthrough x9 = 1111
    add(1,9,32'h1111, 0,0,0,0,     1,9,32'h1111,            0,0, 0,0);
    // JTAG write x0: acked, never written
    add(0,0,0, 1,1,0,32'hFFFFFFFF, 0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,1,0,32'hFFFFFFFF, 0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,1,0,32'hFFFFFFFF, 0,0,0,                   1,0, 0,0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 0,0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);
    // JTAG read x0 returns 0 even though the model holds junk there
    add(0,0,0, 1,0,0,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,0,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,0,0,            0,0,0,                   1,0, 1,32'h0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 1,32'h0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);
    // JTAG read x3 with same-cycle core write x3 = A5A5A5A5 (forwarded)
    add(0,0,0, 1,0,3,0,            0,0,0,                   0,0, 0,0);
    add(1,3,32'hA5A5A5A5, 1,0,3,0, 1,3,32'hA5A5A5A5,        0,0, 0,0);
    add(0,0,0, 1,0,3,0,            0,0,0,                   1,0, 1,32'hA5A5A5A5);
    // req held 5 more cycles with changing jtag inputs: ack/rdata stable
    for (int k = 0; k < 5; k++)
      add(0,0,0, 1,1,7,32'h77777777, 0,0,0,                 1,0, 1,32'hA5A5A5A5);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 1,32'hA5A5A5A5);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);
    // new request accepted: read x9 written earlier by core
    add(0,0,0, 1,0,9,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,9,0,            0,0,0,                   0,0, 0,0);
    add(0,0,0, 1,0,9,0,            0,0,0,                   1,0, 1,32'h1111);
    add(0,0,0, 0,0,0,0,            0,0,0,                   1,0, 0,0);
    add(0,0,0, 0,0,0,0,            0,0,0,                   0,0, 0,0);

    // ---------------- reset state ----------------
    cyc(); cyc();
    @(negedge clk);
    chk("rst_ack",   {31'd0, jtag_ack_o}, 32'd0);
    chk("rst_hold",  {31'd0, hold_req_o}, 32'd0);
    chk("rst_wr_en", {31'd0, rf_wr_en_o}, 32'd0);
    chk("rst_rdata", jtag_rdata_o, 32'd0);
    chk("rst_rdaddr", {27'd0, rf_rd_addr_o}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // ---------------- table replay ----------------
    foreach (vecs[i]) begin
      core_wr_en_i = vecs[i].ce; core_wr_addr_i = vecs[i].ca; core_wr_data_i = vecs[i].cd;
      jtag_req_i = vecs[i].rq; jtag_we_i = vecs[i].we;
      jtag_addr_i = vecs[i].ja; jtag_wdata_i = vecs[i].jd;
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", i), {31'd0, rf_wr_en_o}, {31'd0, vecs[i].e_en});
      chk($sformatf("v%0d_ack", i),   {31'd0, jtag_ack_o}, {31'd0, vecs[i].e_ack});
      chk($sformatf("v%0d_hold", i),  {31'd0, hold_req_o}, {31'd0, vecs[i].e_hold});
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d_wr_addr", i), {27'd0, rf_wr_addr_o}, {27'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_wr_data", i), rf_wr_data_o, vecs[i].e_data);
      end
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), jtag_rdata_o, vecs[i].e_rd);
      cyc();
    end
    core_wr_en_i = 1'b0; jtag_req_i = 1'b0;

    // ---------------- starvation: core writes x7 every cycle ----------------
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd7; jtag_wdata_i = 32'h12345678;
    core_wr_en_i = 1'b1; core_wr_addr_i = 5'd7; core_wr_data_i = 32'h100;
    @(negedge clk);
    chk("stv_c0_hold", {31'd0, hold_req_o}, 32'd0);
    cyc();
    for (int n = 1; n <= 8; n++) begin
      core_wr_data_i = 32'h100 + n;
      @(negedge clk);
      chk($sformatf("stv_c%0d_hold", n), {31'd0, hold_req_o}, 32'd0);
      chk($sformatf("stv_c%0d_data", n), rf_wr_data_o, 32'h100 + n);
      cyc();
    end
    core_wr_data_i = 32'h109;
    @(negedge clk);
    chk("stv_c9_hold", {31'd0, hold_req_o}, 32'd1);
    chk("stv_c9_ack",  {31'd0, jtag_ack_o}, 32'd0);
    cyc();
    core_wr_en_i = 1'b0;
    @(negedge clk);
    chk("stv_grant_en",   {31'd0, rf_wr_en_o}, 32'd1);
    chk("stv_grant_addr", {27'd0, rf_wr_addr_o}, 32'd7);
    chk("stv_grant_data", rf_wr_data_o, 32'h12345678);
    cyc();
    jtag_req_i = 1'b0;
    @(negedge clk);
    chk("stv_ack",       {31'd0, jtag_ack_o}, 32'd1);
    chk("stv_hold_clr",  {31'd0, hold_req_o}, 32'd0);
    chk("stv_no_wr",     {31'd0, rf_wr_en_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk("stv_ack_low", {31'd0, jtag_ack_o}, 32'd0);
    cyc();

    // ---------------- reset in WPEND ----------------
    jtag_req_i = 1'b1; jtag_we_i = 1'b1; jtag_addr_i = 5'd4; jtag_wdata_i = 32'hCAFE;
    core_wr_en_i = 1'b1; core_wr_addr_i = 5'd2; core_wr_data_i = 32'h22;
    cyc(); cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ack",   {31'd0, jtag_ack_o}, 32'd0);
    chk("mrst_hold",  {31'd0, hold_req_o}, 32'd0);
    chk("mrst_wr_en", {31'd0, rf_wr_en_o}, 32'd0);
    cyc();
    rst_n = 1'b1; core_wr_en_i = 1'b0; jtag_req_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("mrst_post%0d_wr_en", n), {31'd0, rf_wr_en_o}, 32'd0);
      chk($sformatf("mrst_post%0d_ack", n),   {31'd0, jtag_ack_o}, 32'd0);
      cyc();
    end

    // last writer wins on x7; discarded write never reached x4
    jtag_read(5'd7, 32'h12345678, "rd_x7");
    jtag_read(5'd4, 32'h44, "rd_x4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
